rfrac_conv_sched: RTL
=====================

Name: rfrac_conv_sched

Overview:
- Issue scheduler for the 18-bit, 6-digit RNS-to-mixed-radix fractional converter, stage 1. The stage-1 datapath has a fixed latency and no valid or stall signalling.
- This block arbitrates round-robin between NUM_REQ requesters of RNS words, issues at most one word per cycle into the datapath, and tracks each word's requester tag through the pipeline.
- It captures the mixed-radix digits mr_A3..mr_A6 into an output FIFO. A credit count guarantees no result is ever lost.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DIGIT_W, 18, RNS/mixed-radix digit width
- PIPE_LAT, 6, datapath latency in clocks, from a digit-input change to the corresponding mr_A* outputs
- FIFO_DEPTH, 4, output FIFO entries; this is also the issue credit limit (power of two)
- TAG_W, 1, requester tag width; must satisfy 2**TAG_W >= NUM_REQ

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: drops in-flight words and FIFO contents
- req_valid  in  NUM_REQ  per-requester word valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_rns  in  NUM_REQ*6*DIGIT_W  per-requester digits; digit D1 is in the LSBs
- conv_rns  out  6*DIGIT_W  registered drive to datapath RNS_D1..D6_in
- conv_mr  in  4*DIGIT_W  datapath mr_A3..A6_out; A3 is in the LSBs
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accept
- out_mr  out  4*DIGIT_W  FIFO head digits
- out_tag  out  TAG_W  FIFO head requester index
- busy  out  1  in-flight count or FIFO occupancy is nonzero

Behaviour:
- Reset (reset_n=0, asynchronous) values:
  - req_ready=0, conv_rns=0, out_valid=0, out_mr=0, out_tag=0, busy=0
  - Round-robin pointer set to requester 0
  - Valid/tag shift register, FIFO pointers and credit counter cleared
- Credits:
  - credits_used = in-flight words + FIFO occupancy, range 0..FIFO_DEPTH
  - Issue is permitted only when credits_used < FIFO_DEPTH, or when credits_used == FIFO_DEPTH and a pop occurs in the same cycle
- Arbitration:
  - Round-robin. Search starts at (last_grant+1) mod NUM_REQ.
  - req_ready[k] is asserted combinationally only for the selected k, only when issue is permitted, and only when clr=0.
  - A transfer occurs when req_valid[k] && req_ready[k]. The pointer advances only on a transfer.
- Issue:
  - On a transfer, conv_rns <= req_rns[k] and the tag k enters stage 0 of a PIPE_LAT-deep valid/tag shift register.
  - On non-transfer cycles conv_rns <= 0 (idle datapath input is all-zero) and a 0 valid enters the shift register.
- Capture:
  - When the shift register's final stage is valid, conv_mr and the tag are written into the FIFO in that cycle.
  - By the credit rule the FIFO is never full at this point. The bench asserts that it is not.
- Output:
  - FIFO is first-word fall-through: out_valid = occupancy != 0.
  - A pop occurs on out_valid && out_ready.
  - Simultaneous push and pop leaves occupancy unchanged.
  - The head is stable while out_valid && !out_ready.
- Credit counter update:
  - +1 on issue, -1 on pop; issue and pop in the same cycle leave it unchanged.
  - The counter never exceeds FIFO_DEPTH and never underflows.
- clr:
  - Valid bits, FIFO pointers and credit counter go to 0; out_valid=0 next cycle.
  - Round-robin pointer is held.
  - No transfer occurs in the clr cycle.
  - Data already in the datapath emerges later with valid=0 and is discarded.
- Reset asserted mid-operation behaves as clr but acts asynchronously; the round-robin pointer also returns to 0.
- Latency: a transfer at edge N produces a FIFO write at edge N+1+PIPE_LAT; out_valid rises after that edge.
- Throughput: one word per clock while the consumer keeps out_ready=1.

Decomposition:
- Shared package rfrac_pkg holds:
  - RNS_DIGITS=6, MR_DIGITS=4
  - typedefs rns_word_t (6 x 18b) and mr_word_t (4 x 18b)
  - the stage-1 latency constant RFRAC_STG1_LAT, used as the default for PIPE_LAT
- One sub-module, rfrac_res_fifo: a FWFT FIFO of {tag, mr_word_t}, FIFO_DEPTH entries, with a synchronous clear.
- Arbiter, valid/tag shift register and credit counter stay in the top module.

Test Plan:
- Single word, datapath stub = PIPE_LAT delay line mapping D3..D6 to A3..A6:
  - Stimulus: requester 0 sends D1..D6 = 'hd70, 'h178e8, 'h8250, 'h17741, 'h28ddc, 'h25d.
  - Response: out_valid at transfer+1+PIPE_LAT, out_mr = {'h25d, 'h28ddc, 'h17741, 'h8250}, out_tag=0; conv_rns=0 on all other cycles.
- Fairness:
  - Stimulus: both requesters hold valid for 8 cycles, out_ready=1.
  - Response: grants alternate 0,1,0,1…; out_tag sequence 0,1,0,1…; 8 results, in order.
- Backpressure:
  - Stimulus: out_ready=0, requester 0 continuously valid.
  - Response: exactly FIFO_DEPTH=4 transfers, then req_ready=0. Raising out_ready for 1 cycle allows exactly 1 further transfer. No result is lost; the bench checks that no write occurs while the FIFO is full.
- Simultaneous issue and pop at full credits:
  - Response: issue proceeds; the credit count stays at 4.
- clr mid-flight:
  - Stimulus: 3 words issued, clr pulsed 2 cycles later.
  - Response: out_valid stays 0, busy=0 the cycle after clr, and no late words appear.
- Async reset during traffic:
  - Response: all outputs return to their reset values immediately; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/rfrac_pkg.sv
// Shared types and constants for the RNS-to-mixed-radix fractional converter.
// The digit-word typedefs keep digit 1 (D1 / A3) in the least-significant slot.
package rfrac_pkg;

    localparam int RNS_DIGITS     = 6;
    localparam int MR_DIGITS      = 4;
    localparam int RFRAC_DIGIT_W  = 18;
    localparam int RFRAC_STG1_LAT = 6;

    typedef logic [RNS_DIGITS-1:0][RFRAC_DIGIT_W-1:0] rns_word_t;
    typedef logic [MR_DIGITS-1:0][RFRAC_DIGIT_W-1:0]  mr_word_t;

    // Requester index reached by stepping 'offset' places from 'base' around the ring.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rfrac_conv_sched_if.sv
// Request and result handshake buses of the stage-1 issue scheduler.
// The scheduler takes the slave modport; requesters/consumer take master.
interface rfrac_conv_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int DIGIT_W = 18,
    parameter int TAG_W   = 1
) ();
    import rfrac_pkg::*;

    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_ready;
    logic [NUM_REQ*RNS_DIGITS*DIGIT_W-1:0] req_rns;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [MR_DIGITS*DIGIT_W-1:0]          out_mr;
    logic [TAG_W-1:0]                      out_tag;

    modport master (
        output req_valid, req_rns, out_ready,
        input  req_ready, out_valid, out_mr, out_tag
    );

    modport slave (
        input  req_valid, req_rns, out_ready,
        output req_ready, out_valid, out_mr, out_tag
    );

endinterface

// File: rtl/rfrac_res_fifo.sv
// First-word-fall-through result FIFO holding {tag, mixed-radix digits}.
// Synchronous clear empties it; depth must be a power of two.
module rfrac_res_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 73
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    localparam int            PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; head_valid qualifies every read of it.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign head_valid = (wr_ptr != rd_ptr);
    assign head_data  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/rfrac_conv_sched.sv
// Stage-1 issue scheduler: round-robin arbitration into a fixed-latency datapath,
// tag tracking alongside it, and credit-limited capture of results into a FIFO.
module rfrac_conv_sched
    import rfrac_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DIGIT_W    = RFRAC_DIGIT_W,
    parameter int PIPE_LAT   = RFRAC_STG1_LAT,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clr,
    rfrac_conv_sched_if.slave             bus,
    output logic [RNS_DIGITS*DIGIT_W-1:0] conv_rns,
    input  logic [MR_DIGITS*DIGIT_W-1:0]  conv_mr,
    output logic                          busy
);

    localparam int RNS_W  = RNS_DIGITS * DIGIT_W;
    localparam int MR_W   = MR_DIGITS * DIGIT_W;
    localparam int RES_W  = TAG_W + MR_W;
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE  = 1;

    logic [TAG_W-1:0]               rr_ptr;
    logic [TAG_W-1:0]               grant_idx;
    logic                           grant_found;
    logic                           issue_ok;
    logic                           xfer;
    logic                           pop;
    logic [CRED_W-1:0]              credits;
    logic [PIPE_LAT:0]              vld_sr;
    logic [PIPE_LAT:0][TAG_W-1:0]   tag_sr;
    logic                           res_push;
    logic                           head_valid;
    logic [RES_W-1:0]               head_data;

    assign pop      = bus.out_valid && bus.out_ready;
    assign issue_ok = (credits != CRED_FULL) || pop;

    // rr_ptr holds the first requester to consider, i.e. last grant + 1.
    always_comb begin
        // NOTE: blocking assignments with defaults first keep this block latch-free.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req_valid[rr_index(int'(rr_ptr), i, NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'(rr_index(int'(rr_ptr), i, NUM_REQ));
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_found && issue_ok && !clr && reset_n) bus.req_ready[grant_idx] = 1'b1;
    end

    assign xfer = |(bus.req_valid & bus.req_ready);

    // Stage 0 tracks the conv_rns register; stage PIPE_LAT lines up with conv_mr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_rns <= '0;
            rr_ptr   <= '0;
            vld_sr   <= '0;
            tag_sr   <= '0;
        end else begin
            conv_rns <= xfer ? bus.req_rns[int'(grant_idx)*RNS_W +: RNS_W] : '0;
            vld_sr   <= clr ? '0 : {vld_sr[PIPE_LAT-1:0], xfer};
            tag_sr   <= {tag_sr[PIPE_LAT-1:0], grant_idx};
            if (xfer) rr_ptr <= TAG_W'(rr_index(int'(grant_idx), 1, NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits <= '0;
        end else if (clr) begin
            credits <= '0;
        end else if (xfer && !pop) begin
            credits <= credits + CRED_ONE;
        end else if (!xfer && pop) begin
            credits <= credits - CRED_ONE;
        end
    end

    assign res_push = vld_sr[PIPE_LAT];

    rfrac_res_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (RES_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .clr        (clr),
        .push       (res_push),
        .push_data  ({tag_sr[PIPE_LAT], conv_mr}),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign bus.out_valid              = head_valid;
    assign {bus.out_tag, bus.out_mr}  = head_valid ? head_data : '0;
    assign busy                       = (credits != '0);

endmodule
